spi_display_latch: RTL and testbench
====================================

Name: spi_display_latch

Overview:
- Sits directly downstream of the SPI slave: consumes its parallel receive word plus the raw ucSEL_/ucSCLK pins, and drives the two 7-segment digit outputs.
- Each frame is validated by counting SCLK edges, then captured atomically at frame end.
- Supports a raw-segment mode and a hex-decode mode.
- A watchdog blanks the display if the host stops sending frames.

Parameters:
- WIDTH, 16, SPI word width; must be >= 16.
- TIMEOUT, 12000000, clk cycles without a valid frame before blanking; 0 disables the watchdog.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- ucSEL_  input  1  SPI chip select from pin, active-low, asynchronous to clk
- ucSCLK  input  1  SPI clock from pin, asynchronous to clk
- word_in  input  WIDTH  SPI slave data_out; stable once SEL_ is high
- digit1  output  7  low digit segments {g,f,e,d,c,b,a}, active-high
- digit2  output  7  high digit segments, same encoding
- frame_valid  output  1  1-cycle pulse when a good frame is captured
- frame_err  output  1  1-cycle pulse when a frame is rejected
- blanked  output  1  high while the display is blanked by the watchdog

Behaviour:
- Reset: rst_n sampled on the clk rising edge only. While low:
  - all registers clear; digit1 = digit2 = 7'h00; frame_valid = frame_err = 0; blanked = 1; FSM = IDLE.
  - Synchroniser FFs reset to 1 (SEL_ idle) and 0 (SCLK).
- Synchronisation: ucSEL_ and ucSCLK each pass through 2 FFs, plus a third FF for edge detection.
  - SCLK rise = sync==1 and prev==0.
  - SEL_ rise = same rule on the SEL_ chain.
- FSM states:
  - IDLE: wait for synced SEL_ == 0, then go to ACTIVE and clear bitcnt.
  - ACTIVE: each SCLK rise increments bitcnt. bitcnt is $clog2(WIDTH)+2 bits and saturates at all-ones, never wraps. On SEL_ rise, go to CHECK.
  - CHECK: single cycle.
    - If bitcnt == WIDTH: capture word_in into shadow register, pulse frame_valid, clear watchdog, clear blanked.
    - Else: pulse frame_err; shadow register unchanged.
    - Next state: ACTIVE (bitcnt cleared) if synced SEL_ is already 0, else IDLE.
    - SCLK edges seen during CHECK are ignored.
- Latency: frame_valid asserts 4 clk cycles after the ucSEL_ pin rises (2 sync + 1 edge + 1 CHECK). Digits update on the same edge that frame_valid asserts.
- Display decode, from the shadow register (combinational from registered state, no extra latency):
  - Mode bit = shadow[WIDTH-1].
  - Mode 0 (raw): digit1 = shadow[6:0], digit2 = shadow[14:8].
  - Mode 1 (hex): digit1 = hex(shadow[3:0]), digit2 = hex(shadow[7:4]).
  - Hex table 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - When blanked == 1, both digits are forced to 7'h00 regardless of mode.
- Watchdog (TIMEOUT > 0):
  - 24-bit counter increments every cycle while not blanked.
  - Reaching TIMEOUT-1 sets blanked on the next edge; the counter holds.
  - A valid frame clears the counter and blanked in the same cycle. A valid frame in the timeout cycle wins.
  - Shadow contents are preserved while blanked; frame_err does not reset the watchdog.
- TIMEOUT = 0: blanked is cleared by the first valid frame and never set again.
- Reset mid-frame: the partial frame is discarded; after reset the FSM waits in IDLE. A SEL_ low already present is treated as a new frame start.

Optional Feature:
- SPI_DISPLAY_ECHO_EN:
  - Defined: adds output echo_out [WIDTH-1:0] = {valid_cnt[7:0], err_cnt[7:0]} zero-extended to WIDTH, intended for the SPI slave's data_in.
    - valid_cnt and err_cnt are 8-bit wrap-around counters (255 -> 0), cleared by reset.
    - Each increments on its pulse; the update is visible the cycle after the pulse.
  - Undefined: no echo_out port and no counters.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with SCLK toggling -> digits 00/00, blanked=1, no pulses.
- Raw mode: send 16-bit 0x3F06 -> frame_valid pulse 4 cycles after SEL_ rise; digit2=7'h3F, digit1=7'h06; blanked=0.
- Hex mode: send 0x80A5 -> digit2=7'h77 (A), digit1=7'h6D (5).
- Bad frame lengths:
  - Send 15 SCLK edges then 17 SCLK edges -> two frame_err pulses, no frame_valid, digits keep the prior value.
  - With echo enabled: err_cnt=2, valid_cnt unchanged.
- Watchdog: TIMEOUT=100, send a valid frame, then idle -> blanked rises exactly 100 cycles after frame_valid and digits go to 00. A new valid frame restores the new word.
- Back-to-back: SEL_ re-asserted in the CHECK cycle, frames 0x0106 then 0x0107 -> two frame_valid pulses; final digit1=7'h07.

Source files
------------

// File: rtl/spi_display_latch.sv
// spi_display_latch
//
// Validates SPI frames coming out of an SPI slave by counting SCLK rising
// edges between chip-select assertion and release. A frame with exactly
// WIDTH edges is captured into a shadow register at frame end. Any other
// edge count is rejected. The shadow register drives two 7-segment digits,
// either as raw segment bits or through a hex decoder. A watchdog blanks
// the display when no valid frame arrives for TIMEOUT clock cycles.
//
// Parameters:
//   WIDTH    SPI word width (>= 16)
//   TIMEOUT  clk cycles without a valid frame before blanking, 0 = never
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   ucSEL_       SPI chip select pin, active-low, asynchronous to clk
//   ucSCLK       SPI clock pin, asynchronous to clk
//   word_in      parallel receive word from the SPI slave, stable once
//                SEL_ is high
//   digit1       low digit segments {g,f,e,d,c,b,a}, active-high
//   digit2       high digit segments, same encoding
//   frame_valid  1-cycle pulse when a good frame is captured
//   frame_err    1-cycle pulse when a frame is rejected
//   blanked      high while the watchdog holds the display dark
//   dbg_state    current FSM state (0 IDLE, 1 ACTIVE, 2 CHECK)
//   echo_out     {valid_cnt, err_cnt} zero-extended to WIDTH
//                (only when SPI_DISPLAY_ECHO_EN is defined)
//
// Optional feature macro: SPI_DISPLAY_ECHO_EN adds the echo_out port and
// the two 8-bit wrap-around frame counters behind it.
//
// Handshake: there is no valid/ready flow control here. frame_valid and
// frame_err are single-cycle, mutually exclusive strobes; the digits take
// their new value on the same clock edge that frame_valid rises.

module spi_display_latch #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 12000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ucSEL_,
   input  logic             ucSCLK,
   input  logic [WIDTH-1:0] word_in,
   output logic [6:0]       digit1,
   output logic [6:0]       digit2,
   output logic             frame_valid,
   output logic             frame_err,
   output logic             blanked,
   output logic [1:0]       dbg_state
`ifdef SPI_DISPLAY_ECHO_EN
   ,
   output logic [WIDTH-1:0] echo_out
`endif
);

   localparam int CW = $clog2(WIDTH) + 2;
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      CHECK  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Pin synchronisers: two FFs for metastability, a third holding the
   // previous synchronised value for rising-edge detection.
   // ------------------------------------------------------------------
   logic sel_s1, sel_sync, sel_prev;
   logic sclk_s1, sclk_sync, sclk_prev;
   logic sel_rise, sclk_rise;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_s1    <= 1'b1;
         sel_sync  <= 1'b1;
         sel_prev  <= 1'b1;
         sclk_s1   <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
      end else begin
         sel_s1    <= ucSEL_;
         sel_sync  <= sel_s1;
         sel_prev  <= sel_sync;
         sclk_s1   <= ucSCLK;
         sclk_sync <= sclk_s1;
         sclk_prev <= sclk_sync;
      end
   end

   assign sel_rise  = sel_sync & ~sel_prev;
   assign sclk_rise = sclk_sync & ~sclk_prev;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [CW-1:0] bitcnt_q, bitcnt_d;
   logic          good, bad;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      good     = 1'b0;
      bad      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!sel_sync) begin
               state_d  = ACTIVE;
               bitcnt_d = '0;
            end
         end
         ACTIVE: begin
            // Saturate so an over-long frame can never wrap back onto
            // the exact WIDTH count.
            if (sclk_rise && (bitcnt_q != CNT_MAX)) begin
               bitcnt_d = bitcnt_q + CW'(1);
            end
            if (sel_rise) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            // SCLK edges in this cycle are deliberately not counted.
            if (bitcnt_q == CNT_FULL) begin
               good = 1'b1;
            end else begin
               bad = 1'b1;
            end
            bitcnt_d = '0;
            // SEL_ may already be low again for a back-to-back frame.
            state_d  = sel_sync ? IDLE : ACTIVE;
         end
         default: begin
            state_d  = IDLE;
            bitcnt_d = '0;
         end
      endcase
   end

   assign dbg_state = state_q;

   // ------------------------------------------------------------------
   // Capture and strobes
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] shadow;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow      <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= good;
         frame_err   <= bad;
         if (good) begin
            shadow <= word_in;
         end
      end
   end

   // ------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------
   logic blank_q;

   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam logic [23:0] WD_LAST = 24'(TIMEOUT - 1);
         logic [23:0] wd_cnt;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               wd_cnt  <= '0;
               blank_q <= 1'b1;
            end else if (good) begin
               // A valid frame beats a simultaneous timeout.
               wd_cnt  <= '0;
               blank_q <= 1'b0;
            end else if (!blank_q) begin
               if (wd_cnt == WD_LAST) begin
                  blank_q <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 24'd1;
               end
            end
         end
      end else begin : g_no_wd
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               blank_q <= 1'b1;
            end else if (good) begin
               blank_q <= 1'b0;
            end
         end
      end
   endgenerate

   assign blanked = blank_q;

   // ------------------------------------------------------------------
   // Segment decode
   // ------------------------------------------------------------------
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] seg;
      case (n)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   always_comb begin
      digit1 = 7'h00;
      digit2 = 7'h00;
      if (!blank_q) begin
         if (shadow[WIDTH-1]) begin
            digit1 = hex7(shadow[3:0]);
            digit2 = hex7(shadow[7:4]);
         end else begin
            digit1 = shadow[6:0];
            digit2 = shadow[14:8];
         end
      end
   end

`ifdef SPI_DISPLAY_ECHO_EN
   // ------------------------------------------------------------------
   // Frame counters echoed back to the host
   // ------------------------------------------------------------------
   logic [7:0] valid_cnt;
   logic [7:0] err_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (frame_valid) begin
            valid_cnt <= valid_cnt + 8'd1;
         end
         if (frame_err) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   assign echo_out = WIDTH'({valid_cnt, err_cnt});
`endif

endmodule

// File: tb/tb_spi_display_latch.sv
// Testbench for spi_display_latch (WIDTH=16, TIMEOUT=100).
// Drives SPI frames on the raw pins, predicts each frame_valid/frame_err
// strobe together with the digits it should show, and compares them when
// the strobe appears.

module tb_spi_display_latch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ucSEL_ = 1'b1;
   logic        ucSCLK = 1'b0;
   logic [15:0] word_in = 16'h0000;
   logic [6:0]  digit1, digit2;
   logic        frame_valid, frame_err, blanked;
   logic [1:0]  dbg_state;
`ifdef SPI_DISPLAY_ECHO_EN
   logic [15:0] echo_out;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   int valid_seen = 0;
   int err_seen   = 0;

   // {frame_valid, frame_err, digit2, digit1}
   logic [15:0] exp_q[$];

   // Bench-side display model
   logic [15:0] shadow_m = 16'h0000;
   logic        blank_m  = 1'b1;
   logic [6:0]  hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "timeout");
   end

   spi_display_latch #(.WIDTH(16), .TIMEOUT(100)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ucSEL_      (ucSEL_),
      .ucSCLK      (ucSCLK),
      .word_in     (word_in),
      .digit1      (digit1),
      .digit2      (digit2),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .blanked     (blanked),
      .dbg_state   (dbg_state)
`ifdef SPI_DISPLAY_ECHO_EN
      ,
      .echo_out    (echo_out)
`endif
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [13:0] disp(input logic [15:0] w, input logic blk);
      logic [3:0] lo, hi;
      lo = w[3:0];
      hi = w[7:4];
      if (blk) return 14'h0;
      if (w[15]) return {hex_tbl[hi], hex_tbl[lo]};
      return {w[14:8], w[6:0]};
   endfunction

   task automatic push_exp(input logic [15:0] w, input logic good);
      if (good) begin
         shadow_m = w;
         blank_m  = 1'b0;
         exp_q.push_back({2'b10, disp(shadow_m, blank_m)});
      end else begin
         exp_q.push_back({2'b01, disp(shadow_m, blank_m)});
      end
   endtask

   // Scoreboard: pop one expectation per strobe
   always @(negedge clk) begin
      if (rst_n && (frame_valid || frame_err)) begin
         if (frame_valid) valid_seen++;
         if (frame_err) err_seen++;
         if (exp_q.size() == 0)
            chk("unexpected_pulse", exp_q.size(), 1);
         else
            chk("pulse", {frame_valid, frame_err, digit2, digit1}, exp_q.pop_front());
      end
   end

   // ---------------- drivers ----------------
   task automatic start_frame();
      ucSEL_ = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic clock_bits(input int n);
      for (int i = 0; i < n; i++) begin
         ucSCLK = 1'b1;
         @(negedge clk);
         ucSCLK = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic finish_frame(input logic [15:0] w, input logic good, input string tag);
      int lat;
      repeat (2) @(negedge clk);
      word_in = w;
      push_exp(w, good);
      ucSEL_ = 1'b1;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (frame_valid || frame_err) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, lat, 4);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;

      // Reset held with SCLK toggling
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ucSCLK = ~ucSCLK;
         chk("rst_pulses", {frame_valid, frame_err}, 2'b00);
      end
      chk("rst_digits", {digit2, digit1}, 14'h0);
      chk("rst_blanked", blanked, 1'b1);
      chk("rst_state", dbg_state, 2'd0);
      ucSCLK = 1'b0;
      rst_n  = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_blanked", blanked, 1'b1);
      chk("post_rst_state", dbg_state, 2'd0);

      // Raw mode
      start_frame();
      clock_bits(16);
      finish_frame(16'h3F06, 1'b1, "raw");
      chk("raw_digits", {digit2, digit1}, {7'h3F, 7'h06});
      chk("raw_blanked", blanked, 1'b0);

      // Hex mode
      start_frame();
      clock_bits(16);
      finish_frame(16'h80A5, 1'b1, "hex");
      chk("hex_digits", {digit2, digit1}, {7'h77, 7'h6D});

      // Bad lengths: 15 then 17 edges
      start_frame();
      clock_bits(15);
      finish_frame(16'hFFFF, 1'b0, "short");
      start_frame();
      clock_bits(17);
      finish_frame(16'h0000, 1'b0, "long");
      chk("bad_digits", {digit2, digit1}, {7'h77, 7'h6D});
`ifdef SPI_DISPLAY_ECHO_EN
      @(negedge clk);
      chk("echo_after_bad", echo_out, 16'h0202);
`endif

      // Watchdog
      start_frame();
      clock_bits(16);
      finish_frame(16'h1234, 1'b1, "wd_frame");
      chk("wd_frame_digits", {digit2, digit1}, {7'h12, 7'h34});
      cyc = 0;
      for (int i = 1; i <= 150; i++) begin
         @(negedge clk);
         if (blanked) begin
            cyc = i;
            break;
         end
      end
      chk("wd_blank_delay", cyc, 100);
      blank_m = 1'b1;
      chk("wd_digits", {digit2, digit1}, 14'h0);

      // 80 edges: a wrapping counter would read 16, saturation must reject
      start_frame();
      clock_bits(80);
      finish_frame(16'h0106, 1'b0, "sat");
      chk("sat_blanked", blanked, 1'b1);

      // New valid frame restores display
      start_frame();
      clock_bits(16);
      finish_frame(16'h8003, 1'b1, "restore");
      chk("restore_digits", {digit2, digit1}, {7'h3F, 7'h4F});
      chk("restore_blanked", blanked, 1'b0);

      // Back-to-back: SEL_ high for one cycle only
      start_frame();
      clock_bits(16);
      repeat (2) @(negedge clk);
      word_in = 16'h0106;
      push_exp(16'h0106, 1'b1);
      ucSEL_ = 1'b1;
      @(negedge clk);
      ucSEL_ = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b2b_check_state", dbg_state, 2'd2);
      @(negedge clk);
      chk("b2b_next_state", dbg_state, 2'd1);
      chk("b2b_first_valid", frame_valid, 1'b1);
      clock_bits(16);
      finish_frame(16'h0107, 1'b1, "b2b2");
      chk("b2b_digit1", digit1, 7'h07);

      // Reset mid-frame with SEL_ still low afterwards
      start_frame();
      clock_bits(8);
      rst_n = 1'b0;
      shadow_m = 16'h0000;
      blank_m  = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_digits", {digit2, digit1}, 14'h0);
      chk("midrst_blanked", blanked, 1'b1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      clock_bits(16);
      finish_frame(16'h0055, 1'b1, "post_midrst");
      chk("post_midrst_digits", {digit2, digit1}, {7'h00, 7'h55});

      repeat (5) @(negedge clk);
`ifdef SPI_DISPLAY_ECHO_EN
      chk("echo_final", echo_out, 16'h0100);
`endif
      chk("queue_empty", exp_q.size(), 0);
      chk("valid_count", valid_seen, 7);
      chk("err_count", err_seen, 3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
